// File: rtl/fork_sel_fifo.sv
// Selection-mask FIFO feeding the sel stream of a dynamic fork stage.
// Optionally swallows all-zero masks and reports them with a one-cycle pulse.
module fork_sel_fifo #(
  parameter int unsigned N_OUP     = 32'd1,
  parameter int unsigned DEPTH     = 32'd4,
  parameter bit          DROP_ZERO = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic [N_OUP-1:0]         mask_i,
  input  logic                     mask_valid_i,
  output logic                     mask_ready_o,
  output logic [N_OUP-1:0]         sel_o,
  output logic                     sel_valid_o,
  input  logic                     sel_ready_i,
  output logic [$clog2(DEPTH):0]   usage_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     dropped_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [N_OUP-1:0] mem_q [DEPTH];
  logic [N_OUP-1:0] mem_d [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             dropped_q, dropped_d;

  logic is_zero;
  logic drop_zero;
  logic push;
  logic pop;

  assign is_zero   = (mask_i == '0);
  assign drop_zero = DROP_ZERO && is_zero;

  assign full_o      = (count_q == CW'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign usage_o     = count_q;
  assign sel_valid_o = !empty_o;
  assign sel_o       = mem_q[rd_ptr_q];
  assign dropped_o   = dropped_q;

  // Droppable masks never occupy a slot, so they are accepted even when full.
  assign mask_ready_o = drop_zero ? !flush_i : (!full_o && !flush_i);

  assign push = mask_valid_i && mask_ready_o && !drop_zero;
  assign pop  = sel_valid_o && sel_ready_i;

  always_comb begin
    mem_d     = mem_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    dropped_d = mask_valid_i && mask_ready_o && drop_zero;

    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = mask_i;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      dropped_q <= 1'b0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      dropped_q <= dropped_d;
    end
  end

  // Payload storage carries no reset; contents are only observed while valid.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_fork_sel_fifo.sv
// Directed bench for fork_sel_fifo: a vector table for single-cycle behaviour,
// plus hand sequences for wrap-around, mid-stream reset and DROP_ZERO=0.
module tb_fork_sel_fifo;

  logic       clk;
  logic       rst;
  logic       a_flush, a_valid, a_ready_in;
  logic [3:0] a_mask;
  logic       a_mready, a_sel_valid, a_full, a_empty, a_dropped;
  logic [3:0] a_sel;
  logic [2:0] a_usage;

  logic       b_flush, b_valid, b_ready_in;
  logic [3:0] b_mask;
  logic       b_mready, b_sel_valid, b_full, b_empty, b_dropped;
  logic [3:0] b_sel;
  logic [2:0] b_usage;

  int total = 0;
  int passed = 0;

  fork_sel_fifo #(.N_OUP(4), .DEPTH(4), .DROP_ZERO(1'b1)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .flush_i(a_flush),
    .mask_i(a_mask), .mask_valid_i(a_valid), .mask_ready_o(a_mready),
    .sel_o(a_sel), .sel_valid_o(a_sel_valid), .sel_ready_i(a_ready_in),
    .usage_o(a_usage), .full_o(a_full), .empty_o(a_empty), .dropped_o(a_dropped)
  );

  fork_sel_fifo #(.N_OUP(4), .DEPTH(4), .DROP_ZERO(1'b0)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .flush_i(b_flush),
    .mask_i(b_mask), .mask_valid_i(b_valid), .mask_ready_o(b_mready),
    .sel_o(b_sel), .sel_valid_o(b_sel_valid), .sel_ready_i(b_ready_in),
    .usage_o(b_usage), .full_o(b_full), .empty_o(b_empty), .dropped_o(b_dropped)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       fl;
    logic [3:0] m;
    logic       v;
    logic       r;
    logic       er;
    logic       esv;
    logic [3:0] es;
    int         eu;
    logic       ef;
    logic       ee;
    logic       ed;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic fl, input logic [3:0] m, input logic v, input logic r,
                     input logic er, input logic esv, input logic [3:0] es, input int eu,
                     input logic ef, input logic ee, input logic ed);
    vec_t t;
    t.fl = fl; t.m = m; t.v = v; t.r = r;
    t.er = er; t.esv = esv; t.es = es; t.eu = eu;
    t.ef = ef; t.ee = ee; t.ed = ed;
    vq.push_back(t);
  endtask

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s[%0d]: got %0d expected %0d", nm, idx, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    a_flush = 0; a_valid = 0; a_ready_in = 0; a_mask = '0;
    b_flush = 0; b_valid = 0; b_ready_in = 0; b_mask = '0;

    //   fl  mask     v  r | er sv sel      u  f  e  d
    add(0, 4'b0000, 0, 0,  1, 0, 4'b0000, 0, 0, 1, 0);  // reset state
    add(0, 4'b0011, 0, 0,  1, 0, 4'b0000, 0, 0, 1, 0);
    add(0, 4'b0011, 1, 0,  1, 0, 4'b0000, 0, 0, 1, 0);  // push into empty
    add(0, 4'b0100, 1, 0,  1, 1, 4'b0011, 1, 0, 0, 0);  // visible one cycle later
    add(0, 4'b1000, 1, 0,  1, 1, 4'b0011, 2, 0, 0, 0);
    add(0, 4'b0001, 1, 0,  1, 1, 4'b0011, 3, 0, 0, 0);
    add(0, 4'b1111, 1, 0,  0, 1, 4'b0011, 4, 1, 0, 0);  // full: refuse
    add(0, 4'b1111, 0, 1,  0, 1, 4'b0011, 4, 1, 0, 0);  // drain in order
    add(0, 4'b1111, 0, 1,  1, 1, 4'b0100, 3, 0, 0, 0);
    add(0, 4'b1111, 0, 1,  1, 1, 4'b1000, 2, 0, 0, 0);
    add(0, 4'b1111, 0, 1,  1, 1, 4'b0001, 1, 0, 0, 0);
    add(0, 4'b1111, 0, 0,  1, 0, 4'b0000, 0, 0, 1, 0);
    add(0, 4'b1001, 1, 0,  1, 0, 4'b0000, 0, 0, 1, 0);  // refill
    add(0, 4'b1010, 1, 0,  1, 1, 4'b1001, 1, 0, 0, 0);
    add(0, 4'b1011, 1, 0,  1, 1, 4'b1001, 2, 0, 0, 0);
    add(0, 4'b1100, 1, 0,  1, 1, 4'b1001, 3, 0, 0, 0);
    add(0, 4'b1111, 1, 1,  0, 1, 4'b1001, 4, 1, 0, 0);  // full+pop: pop only
    add(0, 4'b1111, 1, 0,  1, 1, 4'b1010, 3, 0, 0, 0);  // accepted next cycle
    add(0, 4'b0000, 1, 0,  1, 1, 4'b1010, 4, 1, 0, 0);  // zero dropped while full
    add(0, 4'b0000, 0, 0,  1, 1, 4'b1010, 4, 1, 0, 1);
    add(0, 4'b1111, 0, 0,  0, 1, 4'b1010, 4, 1, 0, 0);  // pulse lasts one cycle
    add(0, 4'b1111, 0, 1,  0, 1, 4'b1010, 4, 1, 0, 0);
    add(0, 4'b1111, 0, 1,  1, 1, 4'b1011, 3, 0, 0, 0);
    add(0, 4'b1111, 0, 1,  1, 1, 4'b1100, 2, 0, 0, 0);
    add(0, 4'b1111, 0, 1,  1, 1, 4'b1111, 1, 0, 0, 0);
    add(0, 4'b1111, 0, 0,  1, 0, 4'b0000, 0, 0, 1, 0);
    add(0, 4'b0001, 1, 0,  1, 0, 4'b0000, 0, 0, 1, 0);  // build to 3 then flush
    add(0, 4'b0010, 1, 0,  1, 1, 4'b0001, 1, 0, 0, 0);
    add(0, 4'b0100, 1, 0,  1, 1, 4'b0001, 2, 0, 0, 0);
    add(1, 4'b1000, 1, 1,  0, 1, 4'b0001, 3, 0, 0, 0);
    add(0, 4'b1010, 1, 0,  1, 0, 4'b0000, 0, 0, 1, 0);
    add(0, 4'b0101, 1, 1,  1, 1, 4'b1010, 1, 0, 0, 0);
    add(0, 4'b0000, 0, 1,  1, 1, 4'b0101, 1, 0, 0, 0);
    add(0, 4'b0000, 0, 0,  1, 0, 4'b0000, 0, 0, 1, 0);

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (vq[i]) begin
      a_flush = vq[i].fl; a_mask = vq[i].m; a_valid = vq[i].v; a_ready_in = vq[i].r;
      #3;
      chk("mask_ready", i, int'(a_mready), int'(vq[i].er));
      chk("sel_valid", i, int'(a_sel_valid), int'(vq[i].esv));
      if (vq[i].esv) chk("sel", i, int'(a_sel), int'(vq[i].es));
      chk("usage", i, int'(a_usage), vq[i].eu);
      chk("full", i, int'(a_full), int'(vq[i].ef));
      chk("empty", i, int'(a_empty), int'(vq[i].ee));
      chk("dropped", i, int'(a_dropped), int'(vq[i].ed));
      tick();
    end

    // Continuous push/pop across pointer wrap-around.
    a_flush = 0;
    for (int k = 0; k <= 10; k++) begin
      a_mask = 4'(k + 1); a_valid = 1; a_ready_in = 1;
      #3;
      if (k > 0) begin
        chk("wrap_sel", k, int'(a_sel), k);
        chk("wrap_usage", k, int'(a_usage), 1);
      end else begin
        chk("wrap_usage", k, int'(a_usage), 0);
      end
      tick();
    end

    // Reset mid-stream while a push and a pop are both requested.
    a_mask = 4'd12; rst = 1'b1;
    #3;
    chk("pre_rst_sel", 0, int'(a_sel), 11);
    tick();
    rst = 1'b0; a_valid = 0; a_ready_in = 0; a_mask = 4'b0101;
    #3;
    chk("rst_usage", 0, int'(a_usage), 0);
    chk("rst_sel_valid", 0, int'(a_sel_valid), 0);
    chk("rst_empty", 0, int'(a_empty), 1);
    chk("rst_dropped", 0, int'(a_dropped), 0);
    chk("rst_mready", 0, int'(a_mready), 1);
    tick();
    #3;
    chk("rst_usage", 1, int'(a_usage), 0);
    chk("rst_sel_valid", 1, int'(a_sel_valid), 0);
    tick();

    // DROP_ZERO=0: zero masks occupy slots like any other mask.
    b_mask = 4'b0000; b_valid = 1; b_ready_in = 0;
    for (int k = 0; k < 4; k++) begin
      #3;
      chk("b_fill_mready", k, int'(b_mready), 1);
      chk("b_fill_usage", k, int'(b_usage), k);
      tick();
    end
    #3;
    chk("b_full_mready", 0, int'(b_mready), 0);
    chk("b_full", 0, int'(b_full), 1);
    chk("b_usage", 0, int'(b_usage), 4);
    b_valid = 0; b_ready_in = 1;
    for (int k = 0; k < 4; k++) begin
      #3;
      chk("b_sel_valid", k, int'(b_sel_valid), 1);
      chk("b_sel", k, int'(b_sel), 0);
      chk("b_dropped", k, int'(b_dropped), 0);
      chk("b_usage", k + 1, int'(b_usage), 4 - k);
      tick();
    end
    b_ready_in = 0;
    #3;
    chk("b_empty", 0, int'(b_empty), 1);
    chk("b_sel_valid", 4, int'(b_sel_valid), 0);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fork_sel_fifo.md
FORK_SEL_FIFO -- requirements
Module: fork_sel_fifo

Upstream selection-mask buffer: queues per-transaction output masks and presents them as the sel stream (sel/sel_valid/sel_ready) of the dynamic fork stage.

Interface
REQ-001 SHALL have parameter N_OUP, default 32'd1, the mask width (number of fork outputs), at least 1.
REQ-002 SHALL have parameter DEPTH, default 32'd4, the number of FIFO entries; a power of two, at least 2.
REQ-003 SHALL have parameter DROP_ZERO, default 1'b1; when 1, all-zero masks are consumed and not stored.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port flush_i, input, 1 bit: synchronous clear of the queue contents.
REQ-007 SHALL have port mask_i, input, N_OUP bits: incoming selection mask.
REQ-008 SHALL have port mask_valid_i, input, 1 bit: mask_i is valid.
REQ-009 SHALL have port mask_ready_o, output, 1 bit: the mask is accepted.
REQ-010 SHALL have port sel_o, output, N_OUP bits: head-of-queue mask, driven to the fork's sel_i.
REQ-011 SHALL have port sel_valid_o, output, 1 bit: sel_o is valid.
REQ-012 SHALL have port sel_ready_i, input, 1 bit: the consumer accepts sel_o.
REQ-013 SHALL have port usage_o, output, $clog2(DEPTH)+1 bits: current entry count, 0..DEPTH.
REQ-014 SHALL have ports full_o and empty_o, outputs, 1 bit each: usage_o==DEPTH and usage_o==0 respectively.
REQ-015 SHALL have port dropped_o, output, 1 bit: one-cycle pulse, registered, flagging a dropped zero mask.

Function
REQ-016 SHALL implement a circular buffer with read pointer, write pointer and count, each wrapping modulo DEPTH (count saturating at 0..DEPTH by construction).
REQ-017 SHALL define push as mask_valid_i && mask_ready_o && !(DROP_ZERO && mask_i=='0).
REQ-018 SHALL define pop as sel_valid_o && sel_ready_i.
REQ-019 SHALL drive mask_ready_o = !full_o && !flush_i; when DROP_ZERO=1 and mask_i=='0, it SHALL instead be !flush_i, regardless of full.
REQ-020 SHALL drive sel_valid_o = !empty_o and sel_o = the entry at the read pointer; sel_o SHALL be held stable while sel_valid_o is high and no pop occurs.
REQ-021 SHALL have a latency of exactly 1 cycle from push to visibility; there is no combinational path from mask_i or mask_valid_i to sel_o or sel_valid_o.
REQ-022 SHALL NOT accept a push into a full queue even when a pop occurs in the same cycle; the combinational path from sel_ready_i to mask_ready_o is forbidden.
REQ-023 SHALL leave usage_o unchanged on a simultaneous push and pop, and advance both pointers.
REQ-024 SHALL on flush_i=1 set both pointers and the count to 0 the next cycle; flush has priority over push and pop, and sel_valid_o may still be high during the flush cycle but no pop is recorded.
REQ-025 SHALL set dropped_o=1 in the cycle after a zero-mask handshake when DROP_ZERO=1, and 0 otherwise; when DROP_ZERO=0, zero masks are stored like any other mask.
REQ-026 SHALL preserve mask order (FIFO) across pointer wrap-around.

Reset
REQ-027 SHALL, while rst_i=1 at a clock edge, clear the pointers and count and set dropped_o=0; this takes priority over flush, push and pop.
REQ-028 SHALL have these outputs after reset: usage_o=0, empty_o=1, full_o=0, sel_valid_o=0, dropped_o=0, mask_ready_o=1 (when flush_i=0).
REQ-029 SHALL discard all queued entries when reset is asserted mid-operation; no entry reappears after reset.
REQ-030 SHALL NOT require data storage to be reset; sel_o is a don't-care while sel_valid_o=0.

Verification
REQ-031 SHALL be tested with: N_OUP=4, DEPTH=4: push 4'b0011, 4'b0100, 4'b1000, 4'b0001 with sel_ready_i=0 -> full_o=1, usage_o=4, mask_ready_o=0; then sel_ready_i=1 -> sel_o sequence 0011, 0100, 1000, 0001, then empty_o=1.
REQ-032 SHALL be tested with: a push into an empty queue at cycle t -> sel_valid_o=1 at t+1 with sel_o equal to the pushed mask.
REQ-033 SHALL be tested with: full queue plus sel_ready_i=1 plus mask_valid_i=1 -> mask_ready_o=0 that cycle; the mask is accepted the next cycle; usage_o goes 4->3->4.
REQ-034 SHALL be tested with: DROP_ZERO=1, queue full, mask_i=0 valid -> mask_ready_o=1, usage_o unchanged, dropped_o=1 for exactly one cycle; with DROP_ZERO=0 -> the zero mask is stored and popped.
REQ-035 SHALL be tested with: usage_o=3 plus flush_i=1 plus simultaneous push and pop -> usage_o=0, empty_o=1 next cycle; a later push/pop sequence is correct.
REQ-036 SHALL be tested with: 10 continuous push/pop pairs over DEPTH=4 (wrap-around), then rst_i=1 mid-stream -> order preserved before reset; after reset usage_o=0 and sel_valid_o=0.
